// File: rtl/l0p_width_change_ctrl.sv
// l0p_width_change_ctrl: L0p link-width negotiation controller.
// Consumes decoded link-management DLLP fields, runs the local request /
// remote response handshake, drives outbound L0p DLLP fields and tracks
// the negotiated link width.
// Optional build macro L0P_STATS_EN adds saturating NAK / timeout counters.
module l0p_width_change_ctrl #(
   parameter logic [2:0] MAX_WIDTH_CODE = 3'd4,
   parameter int         TIMEOUT_CYCLES = 1024,
   parameter logic [3:0] CMD_REQ        = 4'h1,
   parameter logic [3:0] CMD_ACK        = 4'h2,
   parameter logic [3:0] CMD_NAK        = 4'h3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_valid,
   input  logic        rx_is_lm,
   input  logic        rx_is_l0p,
   input  logic [3:0]  rx_cmd,
   input  logic [2:0]  rx_width,
   input  logic        local_req_valid,
   input  logic [2:0]  local_req_width,
   output logic        local_req_ready,
   input  logic        local_priority,
   output logic        req_done,
   output logic        req_status,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic [3:0]  tx_cmd,
   output logic [2:0]  tx_width,
   output logic        tx_priority,
   output logic [2:0]  cur_width,
   output logic        width_change,
   output logic        busy,
`ifdef L0P_STATS_EN
   output logic [15:0] nak_count,
   output logic [15:0] timeout_count,
`endif
   output logic        timeout_err
);

   localparam int            TW    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, TX_REQ, WAIT_RSP, TX_RSP} state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [2:0]    pend_width_q, pend_width_d;
   logic [2:0]    rsp_width_q, rsp_width_d;
   logic [3:0]    rsp_cmd_q, rsp_cmd_d;
   logic [2:0]    cur_width_q, cur_width_d;
   logic          tx_valid_q, tx_valid_d;
   logic [3:0]    tx_cmd_q, tx_cmd_d;
   logic [2:0]    tx_width_q, tx_width_d;
   logic          tx_priority_q, tx_priority_d;
   logic          width_change_q, width_change_d;
   logic          req_done_q, req_done_d;
   logic          req_status_q, req_status_d;
   logic          timeout_err_q, timeout_err_d;
`ifdef L0P_STATS_EN
   logic [15:0]   nak_count_q, nak_count_d;
   logic [15:0]   timeout_count_q, timeout_count_d;
`endif

   logic       rx_hit, rx_hit_req, rx_ack, rx_nak, rx_legal, tx_fire;
   logic       local_accept, local_bad;
   logic [3:0] rsp_cmd_new;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign rx_hit          = rx_valid & rx_is_lm & rx_is_l0p;
   assign rx_hit_req      = rx_hit & (rx_cmd == CMD_REQ);
   assign rx_ack          = rx_hit & (rx_cmd == CMD_ACK);
   assign rx_nak          = rx_hit & (rx_cmd == CMD_NAK);
   assign rx_legal        = (rx_width <= MAX_WIDTH_CODE);
   assign rsp_cmd_new     = rx_legal ? CMD_ACK : CMD_NAK;
   assign tx_fire         = tx_valid_q & tx_ready;
   assign local_req_ready = (state_q == IDLE) & ~rx_hit_req;
   assign local_accept    = local_req_valid & local_req_ready;
   assign local_bad       = (local_req_width > MAX_WIDTH_CODE) | (local_req_width == cur_width_q);

   // Next-state, handshake and registered-output computation
   always_comb begin
      state_d        = state_q;
      timer_d        = timer_q;
      pend_width_d   = pend_width_q;
      rsp_width_d    = rsp_width_q;
      rsp_cmd_d      = rsp_cmd_q;
      cur_width_d    = cur_width_q;
      tx_valid_d     = tx_valid_q;
      tx_cmd_d       = tx_cmd_q;
      tx_width_d     = tx_width_q;
      tx_priority_d  = local_priority;
      width_change_d = 1'b0;
      req_done_d     = 1'b0;
      req_status_d   = 1'b0;
      timeout_err_d  = 1'b0;
`ifdef L0P_STATS_EN
      nak_count_d     = nak_count_q;
      timeout_count_d = timeout_count_q;
`endif
      case (state_q)
         IDLE: begin
            if (rx_hit_req) begin
               rsp_width_d = rx_width;
               rsp_cmd_d   = rsp_cmd_new;
               tx_valid_d  = 1'b1;
               tx_cmd_d    = rsp_cmd_new;
               tx_width_d  = rx_width;
               state_d     = TX_RSP;
            end else if (local_accept) begin
               if (local_bad) begin
                  req_done_d   = 1'b1;
                  req_status_d = 1'b1;
               end else begin
                  pend_width_d = local_req_width;
                  tx_valid_d   = 1'b1;
                  tx_cmd_d     = CMD_REQ;
                  tx_width_d   = local_req_width;
                  state_d      = TX_REQ;
               end
            end
         end
         TX_REQ: begin
            if (tx_fire) begin
               tx_valid_d = 1'b0;
               timer_d    = '0;
               state_d    = WAIT_RSP;
            end
         end
         WAIT_RSP: begin
            timer_d = timer_q + TW'(1);
            if (rx_ack && (rx_width == pend_width_q)) begin
               cur_width_d    = pend_width_q;
               width_change_d = 1'b1;
               req_done_d     = 1'b1;
               state_d        = IDLE;
            end else if (rx_ack || rx_nak) begin
               req_done_d   = 1'b1;
               req_status_d = 1'b1;
               state_d      = IDLE;
`ifdef L0P_STATS_EN
               if (rx_nak) nak_count_d = sat_inc16(nak_count_q);
`endif
            end else if (rx_hit_req && !local_priority) begin
               req_done_d   = 1'b1;
               req_status_d = 1'b1;
               rsp_width_d  = rx_width;
               rsp_cmd_d    = rsp_cmd_new;
               tx_valid_d   = 1'b1;
               tx_cmd_d     = rsp_cmd_new;
               tx_width_d   = rx_width;
               state_d      = TX_RSP;
            end else if (timer_q == TLAST) begin
               timeout_err_d = 1'b1;
               req_done_d    = 1'b1;
               req_status_d  = 1'b1;
               state_d       = IDLE;
`ifdef L0P_STATS_EN
               timeout_count_d = sat_inc16(timeout_count_q);
`endif
            end
         end
         TX_RSP: begin
            if (tx_fire) begin
               tx_valid_d = 1'b0;
               state_d    = IDLE;
               if (rsp_cmd_q == CMD_ACK) begin
                  cur_width_d    = rsp_width_q;
                  width_change_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Control and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         timer_q        <= '0;
         cur_width_q    <= MAX_WIDTH_CODE;
         tx_valid_q     <= 1'b0;
         tx_cmd_q       <= 4'h0;
         tx_width_q     <= 3'd0;
         tx_priority_q  <= 1'b0;
         width_change_q <= 1'b0;
         req_done_q     <= 1'b0;
         req_status_q   <= 1'b0;
         timeout_err_q  <= 1'b0;
`ifdef L0P_STATS_EN
         nak_count_q     <= 16'd0;
         timeout_count_q <= 16'd0;
`endif
      end else begin
         state_q        <= state_d;
         timer_q        <= timer_d;
         cur_width_q    <= cur_width_d;
         tx_valid_q     <= tx_valid_d;
         tx_cmd_q       <= tx_cmd_d;
         tx_width_q     <= tx_width_d;
         tx_priority_q  <= tx_priority_d;
         width_change_q <= width_change_d;
         req_done_q     <= req_done_d;
         req_status_q   <= req_status_d;
         timeout_err_q  <= timeout_err_d;
`ifdef L0P_STATS_EN
         nak_count_q     <= nak_count_d;
         timeout_count_q <= timeout_count_d;
`endif
      end
   end

   // Latched request/response fields, only meaningful once loaded
   always_ff @(posedge clk) begin
      pend_width_q <= pend_width_d;
      rsp_width_q  <= rsp_width_d;
      rsp_cmd_q    <= rsp_cmd_d;
   end

   assign busy         = (state_q != IDLE);
   assign cur_width    = cur_width_q;
   assign tx_valid     = tx_valid_q;
   assign tx_cmd       = tx_cmd_q;
   assign tx_width     = tx_width_q;
   assign tx_priority  = tx_priority_q;
   assign width_change = width_change_q;
   assign req_done     = req_done_q;
   assign req_status   = req_status_q;
   assign timeout_err  = timeout_err_q;
`ifdef L0P_STATS_EN
   assign nak_count     = nak_count_q;
   assign timeout_count = timeout_count_q;
`endif

endmodule

// File: doc/l0p_width_change_ctrl.md
Name: l0p_width_change_ctrl

Overview:
- Link-management L0p width negotiation controller.
- Sits directly downstream of the link-management DLLP field decoder and consumes its decoded fields.
- Runs the local request / remote response handshake that changes the active link width.
- Emits outbound L0p DLLP fields to the DLLP transmit path and tracks the current negotiated width.

Parameters:
- MAX_WIDTH_CODE, 3'd4, highest legal width code (0=x1, 1=x2, 2=x4, 3=x8, 4=x16); also the reset width.
- TIMEOUT_CYCLES, 1024, cycles to wait for a response before abandoning a local request (>=2).
- CMD_REQ, 4'h1, L0p command code for a width request.
- CMD_ACK, 4'h2, L0p command code for acceptance.
- CMD_NAK, 4'h3, L0p command code for rejection.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- rx_valid  in  1  decoder outputs valid this cycle.
- rx_is_lm  in  1  DLLP is link management.
- rx_is_l0p  in  1  mgmt type is L0p.
- rx_cmd  in  4  decoded L0p command.
- rx_width  in  3  decoded link width.
- local_req_valid  in  1  link layer requests a width change.
- local_req_width  in  3  requested width code.
- local_req_ready  out  1  request accepted when valid&ready.
- local_priority  in  1  local side wins request collisions.
- req_done  out  1  one-cycle pulse: local request finished.
- req_status  out  1  qualified by req_done (0=success, 1=fail).
- tx_valid  out  1  outbound L0p DLLP valid.
- tx_ready  in  1  transmit path accepts.
- tx_cmd  out  4  outbound command.
- tx_width  out  3  outbound width.
- tx_priority  out  1  equals local_priority.
- cur_width  out  3  current negotiated width.
- width_change  out  1  one-cycle pulse when cur_width updates.
- busy  out  1  state != IDLE.
- timeout_err  out  1  one-cycle pulse on response timeout.

Behaviour:
- Reset values: state IDLE, cur_width=MAX_WIDTH_CODE, tx_valid=0, tx_cmd=0, tx_width=0, all pulses 0, timer 0.
- A received DLLP counts only when rx_valid & rx_is_lm & rx_is_l0p; all other inputs are ignored. rx_hit_req = counted DLLP with rx_cmd==CMD_REQ.
- A width is legal iff width<=MAX_WIDTH_CODE.
- States: IDLE, TX_REQ, WAIT_RSP, TX_RSP.
- IDLE:
  - local_req_ready = (state==IDLE) & !rx_hit_req. Remote request wins a same-cycle collision.
  - Accepted local request with illegal width, or width==cur_width: req_done=1, req_status=1 next cycle, stay IDLE, no tx.
  - Otherwise latch pend_width and go to TX_REQ.
  - rx_hit_req: latch rsp_width=rx_width; rsp_cmd=ACK if legal else NAK; go to TX_RSP.
- TX_REQ:
  - tx_valid=1, tx_cmd=CMD_REQ, tx_width=pend_width; fields stay stable until tx_ready.
  - On tx_valid&tx_ready: go to WAIT_RSP, timer=0.
  - Received DLLPs are ignored.
- WAIT_RSP: timer increments each cycle. Priority order, highest first:
  - ACK with rx_width==pend_width: cur_width<=pend_width, width_change=1, req_done=1/status 0, go to IDLE.
  - ACK with any other width, or NAK: req_done=1/status 1, go to IDLE.
  - rx_hit_req with local_priority=0: abandon (req_done=1/status 1) and go to TX_RSP as from IDLE. With local_priority=1 the remote request is ignored.
  - timer==TIMEOUT_CYCLES-1: timeout_err=1, req_done=1/status 1, go to IDLE.
  - A response arriving on the timeout cycle wins.
- TX_RSP:
  - tx_valid=1, tx_cmd=rsp_cmd, tx_width=rsp_width.
  - On handshake: if ACK, cur_width<=rsp_width and width_change=1 in the following cycle; go to IDLE.
  - Received DLLPs are ignored.
- All outputs are registered except local_req_ready and busy. The handshake to req_done pulse has 1-cycle latency.
- rst asserted mid-operation returns to the reset values on the next edge; no pulses are emitted.

Optional Feature:
- L0P_STATS_EN defined:
  - Adds outputs nak_count[15:0] and timeout_count[15:0], reset to 0.
  - nak_count increments on each received NAK in WAIT_RSP; timeout_count increments on each timeout.
  - Both saturate at 16'hFFFF.
- Not defined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then local_req 3'd2 with tx_ready=1 -> tx REQ width 2 for one cycle; rx ACK width 2 -> cur_width=2, width_change and req_done status 0 pulses.
- Local req 3'd3, rx NAK -> req_done status 1, cur_width unchanged at 4; with L0P_STATS_EN, nak_count=1.
- Local req 3'd1, no response, TIMEOUT_CYCLES=16 -> timeout_err plus req_done status 1 exactly 16 cycles after WAIT_RSP entry.
- Remote REQ width 7 in IDLE, tx_ready low 3 cycles -> tx NAK width 7 held stable for 4 cycles, cur_width unchanged.
- Local req and remote REQ width 1 in same cycle -> local_req_ready=0, tx ACK width 1, cur_width=1. In WAIT_RSP with local_priority=1, a remote REQ is ignored and a later ACK completes the local request.
- Local req with width==cur_width, or width 5 -> immediate req_done status 1, no tx_valid; rst asserted in WAIT_RSP -> IDLE, cur_width=4, no pulses.
